// File: rtl/bf_pkg.sv
// Shared width and tree-geometry helpers for the beam_former weighted-sum datapath.
package bf_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

   function automatic int unsigned tree_depth(input int unsigned nch);
      return clog2(nch);
   endfunction

   function automatic int unsigned out_width(input int unsigned iw, input int unsigned cw,
                                             input int unsigned nch);
      return iw + cw + clog2(nch);
   endfunction

   // Number of operands alive at a given tree level (level 0 is the tree input).
   function automatic int unsigned level_count(input int unsigned n, input int unsigned lvl);
      return (n + (32'd1 << lvl) - 1) >> lvl;
   endfunction

endpackage

// File: rtl/bf_adder_tree.sv
// Pipelined signed binary adder tree: one registered level per halving, odd operands
// pass through sign-extended so every path has the same latency.
module bf_adder_tree import bf_pkg::*; #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 30
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     ena,
   input  logic [N*W-1:0]           operands,
   output logic [W+clog2(N)-1:0]    sum
);

   localparam int unsigned Depth = tree_depth(N);

   for (genvar l = 0; l <= Depth; l++) begin : g_lvl
      localparam int unsigned Cnt = level_count(N, l);
      localparam int unsigned Wid = W + l;

      logic [Cnt*Wid-1:0] vals;

      if (l == 0) begin : g_in
         assign vals = operands;
      end else begin : g_reg
         localparam int unsigned PCnt = level_count(N, l - 1);
         localparam int unsigned PWid = Wid - 1;

         logic [PCnt*PWid-1:0] prev;
         logic [Cnt*Wid-1:0]   vals_d;

         assign prev = g_lvl[l-1].vals;

         always_comb begin
            vals_d = '0;
            for (int unsigned j = 0; j < Cnt; j++) begin
               if (2 * j + 1 < PCnt) begin
                  vals_d[j*Wid +: Wid] =
                     {prev[(2*j+1)*PWid-1], prev[2*j*PWid +: PWid]} +
                     {prev[(2*j+2)*PWid-1], prev[(2*j+1)*PWid +: PWid]};
               end else begin
                  vals_d[j*Wid +: Wid] = {prev[(2*j+1)*PWid-1], prev[2*j*PWid +: PWid]};
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!resetn) begin
               vals <= '0;
            end else if (ena) begin
               vals <= vals_d;
            end
         end
      end
   end

   assign sum = g_lvl[Depth].vals;

endmodule

// File: rtl/beam_former.sv
// CRPA weighted-sum beamformer: registered per-channel products feeding a pipelined
// adder tree; full precision, one result per enabled clock.
module beam_former import bf_pkg::*; #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned input_width = 14,
   parameter int unsigned coeff_width = 16
) (
   input  logic                                                     clk,
   input  logic                                                     resetn,
   input  logic                                                     ena,
   input  logic [NCH*input_width-1:0]                               data_in,
   input  logic [NCH*coeff_width-1:0]                               coeff,
   output logic signed [out_width(input_width, coeff_width, NCH)-1:0] data_out
);

   localparam int unsigned ProdW = input_width + coeff_width;
   localparam int unsigned OutW  = out_width(input_width, coeff_width, NCH);

   logic [NCH*ProdW-1:0] prod_flat;
   logic [OutW-1:0]      tree_sum;

   for (genvar i = 0; i < NCH; i++) begin : g_mul
      logic signed [ProdW-1:0] d;
      logic signed [ProdW-1:0] c;
      logic signed [ProdW-1:0] p;
      logic        [ProdW-1:0] prod_q;

      // Both operands widened to the product width, so the truncated product is exact.
      assign d = {{coeff_width{data_in[(i+1)*input_width-1]}},
                  data_in[i*input_width +: input_width]};
      assign c = {{input_width{coeff[(i+1)*coeff_width-1]}},
                  coeff[i*coeff_width +: coeff_width]};
      assign p = d * c;

      always_ff @(posedge clk) begin
         if (!resetn) begin
            prod_q <= '0;
         end else if (ena) begin
            prod_q <= p;
         end
      end

      assign prod_flat[i*ProdW +: ProdW] = prod_q;
   end

   bf_adder_tree #(
      .N (NCH),
      .W (ProdW)
   ) u_tree (
      .clk      (clk),
      .resetn   (resetn),
      .ena      (ena),
      .operands (prod_flat),
      .sum      (tree_sum)
   );

   assign data_out = tree_sum;

endmodule

// File: tb/tb_beam_former.sv
// Self-checking bench: NCH=4 main instance plus NCH=1,3,5,8 instances sharing one stimulus bus.
module tb_beam_former;

   localparam int IW    = 14;
   localparam int CW    = 16;
   localparam int MAXCH = 8;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic ena    = 1'b0;
   logic [MAXCH*IW-1:0] data  = '0;
   logic [MAXCH*CW-1:0] coeff = '0;

   logic signed [31:0] o4;
   logic signed [29:0] o1;
   logic signed [31:0] o3;
   logic signed [32:0] o5;
   logic signed [32:0] o8;

   int total = 0;
   int bad   = 0;

   longint q1[$];
   longint q3[$];
   longint q4[$];
   longint q5[$];
   longint q8[$];
   longint last4 = 0;

   always #5 clk = ~clk;

   beam_former #(.NCH(4), .input_width(IW), .coeff_width(CW)) u_dut4 (
      .clk(clk), .resetn(resetn), .ena(ena),
      .data_in(data[4*IW-1:0]), .coeff(coeff[4*CW-1:0]), .data_out(o4));
   beam_former #(.NCH(1), .input_width(IW), .coeff_width(CW)) u_dut1 (
      .clk(clk), .resetn(resetn), .ena(ena),
      .data_in(data[1*IW-1:0]), .coeff(coeff[1*CW-1:0]), .data_out(o1));
   beam_former #(.NCH(3), .input_width(IW), .coeff_width(CW)) u_dut3 (
      .clk(clk), .resetn(resetn), .ena(ena),
      .data_in(data[3*IW-1:0]), .coeff(coeff[3*CW-1:0]), .data_out(o3));
   beam_former #(.NCH(5), .input_width(IW), .coeff_width(CW)) u_dut5 (
      .clk(clk), .resetn(resetn), .ena(ena),
      .data_in(data[5*IW-1:0]), .coeff(coeff[5*CW-1:0]), .data_out(o5));
   beam_former #(.NCH(8), .input_width(IW), .coeff_width(CW)) u_dut8 (
      .clk(clk), .resetn(resetn), .ena(ena),
      .data_in(data), .coeff(coeff), .data_out(o8));

   // Golden weighted sum over the first n channels of the shared bus.
   function automatic longint dot(input int n);
      longint acc;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         acc += longint'($signed(data[i*IW +: IW])) * longint'($signed(coeff[i*CW +: CW]));
      end
      return acc;
   endfunction

   task automatic set_ch(input int i, input int d, input int c);
      data[i*IW +: IW]  = IW'(d);
      coeff[i*CW +: CW] = CW'(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      ena = 1'b1;
      q1.push_back(dot(1));
      q3.push_back(dot(3));
      q4.push_back(dot(4));
      q5.push_back(dot(5));
      q8.push_back(dot(8));
   endtask

   // After a reset the pipeline holds zeros for latency-1 edges.
   task automatic clear_sb();
      q1.delete(); q3.delete(); q4.delete(); q5.delete(); q8.delete();
      repeat (2) q3.push_back(0);
      repeat (2) q4.push_back(0);
      repeat (3) q5.push_back(0);
      repeat (3) q8.push_back(0);
      last4 = 0;
   endtask

   task automatic test_reset();
      longint e;
      resetn = 1'b0;
      ena    = 1'b1;
      for (int i = 0; i < MAXCH; i++) set_ch(i, 100 + i, 3);
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if (o4 !== 32'sd0) begin
            bad++;
            $display("FAIL reset_hold: data_out=%0d expected=0", o4);
         end
      end
      resetn = 1'b1;
      clear_sb();
      for (int k = 0; k < 4; k++) begin
         apply();
         tick();
         e = q4.pop_front();
         last4 = e;
         total++;
         if (o4 !== e[31:0]) begin
            bad++;
            $display("FAIL post_release: data_out=%0d expected=%0d", o4, e);
         end
      end
      resetn = 1'b0;
      tick();
      total++;
      if (o4 !== 32'sd0) begin
         bad++;
         $display("FAIL mid_reset: data_out=%0d expected=0", o4);
      end
      total++;
      if (o8 !== 33'sd0) begin
         bad++;
         $display("FAIL mid_reset_n8: data_out=%0d expected=0", o8);
      end
      resetn = 1'b1;
      clear_sb();
   endtask

   task automatic test_basic();
      longint e;
      for (int i = 0; i < MAXCH; i++) set_ch(i, 0, 0);
      for (int i = 0; i < 4; i++) set_ch(i, i + 1, 10 * (i + 1));
      for (int k = 0; k < 4; k++) begin
         apply();
         tick();
         if (k == 0) for (int i = 0; i < MAXCH; i++) set_ch(i, 0, 0);
         e = q4.pop_front();
         last4 = e;
         total++;
         if (o4 !== e[31:0]) begin
            bad++;
            $display("FAIL basic: data_out=%0d expected=%0d", o4, e);
         end
         if (k == 2) begin
            total++;
            if (o4 !== 32'sd300) begin
               bad++;
               $display("FAIL basic_latency: data_out=%0d expected=300", o4);
            end
         end
      end
   endtask

   task automatic test_extremes();
      longint e;
      for (int i = 0; i < MAXCH; i++) set_ch(i, -8192, -32768);
      for (int k = 0; k < 5; k++) begin
         apply();
         tick();
         if (k == 0) for (int i = 0; i < MAXCH; i++) set_ch(i, 8191, -32768);
         e = q4.pop_front();
         last4 = e;
         total++;
         if (o4 !== e[31:0]) begin
            bad++;
            $display("FAIL extremes: data_out=%0d expected=%0d", o4, e);
         end
         if (k == 2) begin
            total++;
            if (o4 !== 32'sd1073741824) begin
               bad++;
               $display("FAIL extreme_min: data_out=%0d expected=1073741824", o4);
            end
         end
         if (k == 3) begin
            total++;
            if (o4 !== -32'sd1073610752) begin
               bad++;
               $display("FAIL extreme_mixed: data_out=%0d expected=-1073610752", o4);
            end
            total++;
            if (o8 !== 33'sd2147483648) begin
               bad++;
               $display("FAIL extreme_min_n8: data_out=%0d expected=2147483648", o8);
            end
         end
      end
   endtask

   task automatic test_stream();
      longint e;
      for (int i = 0; i < MAXCH; i++) set_ch(i, 0, 0);
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 4; i++) set_ch(i, n, (i == 0) ? 1 : (i == 1) ? -1 : (i == 2) ? 2 : 0);
         apply();
         tick();
         e = q4.pop_front();
         last4 = e;
         total++;
         if (o4 !== e[31:0]) begin
            bad++;
            $display("FAIL stream: data_out=%0d expected=%0d", o4, e);
         end
         if (n >= 2) begin
            total++;
            if (o4 !== 32'(2 * (n - 2))) begin
               bad++;
               $display("FAIL stream_ramp: data_out=%0d expected=%0d", o4, 2 * (n - 2));
            end
         end
      end
   endtask

   task automatic test_ena();
      longint e;
      for (int n = 20; n < 30; n++) begin
         if (n == 25) begin
            for (int i = 0; i < 4; i++) set_ch(i, 999, 7);
            ena = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick();
               total++;
               if (o4 !== last4[31:0]) begin
                  bad++;
                  $display("FAIL ena_freeze: data_out=%0d expected=%0d", o4, last4);
               end
            end
            for (int i = 0; i < 4; i++) set_ch(i, n, (i == 0) ? 1 : (i == 1) ? -1 : (i == 2) ? 2 : 0);
         end
         for (int i = 0; i < 4; i++) set_ch(i, n, (i == 0) ? 1 : (i == 1) ? -1 : (i == 2) ? 2 : 0);
         apply();
         tick();
         e = q4.pop_front();
         last4 = e;
         total++;
         if (o4 !== e[31:0]) begin
            bad++;
            $display("FAIL ena_resume: data_out=%0d expected=%0d", o4, e);
         end
      end
   endtask

   task automatic test_sweep();
      longint e;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      clear_sb();
      for (int v = 0; v < 40; v++) begin
         for (int i = 0; i < MAXCH; i++) begin
            if (v == 0) set_ch(i, -8192, -32768);
            else set_ch(i, int'($urandom_range(0, 16383)) - 8192,
                        int'($urandom_range(0, 65535)) - 32768);
         end
         apply();
         tick();
         e = q1.pop_front();
         total++;
         if (o1 !== e[29:0]) begin
            bad++;
            $display("FAIL sweep_n1: data_out=%0d expected=%0d", o1, e);
         end
         e = q3.pop_front();
         total++;
         if (o3 !== e[31:0]) begin
            bad++;
            $display("FAIL sweep_n3: data_out=%0d expected=%0d", o3, e);
         end
         e = q4.pop_front();
         total++;
         if (o4 !== e[31:0]) begin
            bad++;
            $display("FAIL sweep_n4: data_out=%0d expected=%0d", o4, e);
         end
         e = q5.pop_front();
         total++;
         if (o5 !== e[32:0]) begin
            bad++;
            $display("FAIL sweep_n5: data_out=%0d expected=%0d", o5, e);
         end
         e = q8.pop_front();
         total++;
         if (o8 !== e[32:0]) begin
            bad++;
            $display("FAIL sweep_n8: data_out=%0d expected=%0d", o8, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_stream();
      test_ena();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
